// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// =============================================================================
// pipe_ctrl_if : fetch/EX status in, stage enables and forwarding selects out.
// Revision     : 1.0
// =============================================================================
interface pipe_ctrl_if;
    logic [7:0] if_instr;
    logic       ex_busy;
`ifdef PIPE_CTRL_STEP_EN
    logic       step;
`endif
    logic       pc_en;
    logic       pc_load;
    logic [6:0] pc_target;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_wb_en;
    logic       id_ex_bubble;
    logic       fwd_a_sel;
    logic       fwd_b_sel;
    logic       wb_en;
    logic [2:0] state;

`ifdef PIPE_CTRL_STEP_EN
    modport master (
        input  if_instr, ex_busy, step,
        output pc_en, pc_load, pc_target, if_id_en, id_ex_en, ex_wb_en,
               id_ex_bubble, fwd_a_sel, fwd_b_sel, wb_en, state
    );
    modport slave (
        output if_instr, ex_busy, step,
        input  pc_en, pc_load, pc_target, if_id_en, id_ex_en, ex_wb_en,
               id_ex_bubble, fwd_a_sel, fwd_b_sel, wb_en, state
    );
`else
    modport master (
        input  if_instr, ex_busy,
        output pc_en, pc_load, pc_target, if_id_en, id_ex_en, ex_wb_en,
               id_ex_bubble, fwd_a_sel, fwd_b_sel, wb_en, state
    );
    modport slave (
        output if_instr, ex_busy,
        input  pc_en, pc_load, pc_target, if_id_en, id_ex_en, ex_wb_en,
               id_ex_bubble, fwd_a_sel, fwd_b_sel, wb_en, state
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// =============================================================================
// pipe_ctrl : 3-stage pipeline sequencer (advance, stall, jump flush, EX fwd).
//             PIPE_CTRL_STEP_EN adds a single-step gate on advance.
// Revision  : 1.0
// =============================================================================
module pipe_ctrl (
    input  wire logic   clk,
    input  wire logic   rst_n,
    pipe_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_STALL = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       ret_run_q, ret_run_d;
    logic [7:0] id_instr_q, id_instr_d;
    logic [7:0] ex_instr_q, ex_instr_d;
    logic       id_v_q, id_v_d;
    logic       ex_v_q, ex_v_d;
    logic       wb_v_q, wb_v_d;
    logic       wb_jmp_q, wb_jmp_d;
    logic       fwd_a_q, fwd_a_d;
    logic       fwd_b_q, fwd_b_d;

    logic       step_ok;
    logic       step_hold;
    logic       adv;
    logic       pc_en, pc_load, if_id_en, id_ex_en, ex_wb_en, bubble;
    logic       ex_dst_ok;

`ifdef PIPE_CTRL_STEP_EN
    assign step_ok = bus.step;
`else
    assign step_ok = 1'b1;
`endif

    // The WB destination index lives in the datapath; only validity and
    // jump-ness of the WB slot matter for the write enable.
    assign ex_dst_ok = ex_v_q & ~ex_instr_q[7];

    always_comb begin
        state_d    = state_q;
        ret_run_d  = ret_run_q;
        id_instr_d = id_instr_q;
        ex_instr_d = ex_instr_q;
        id_v_d     = id_v_q;
        ex_v_d     = ex_v_q;
        wb_v_d     = wb_v_q;
        wb_jmp_d   = wb_jmp_q;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
        step_hold  = 1'b0;
        adv        = 1'b0;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        if_id_en   = 1'b0;
        id_ex_en   = 1'b0;
        ex_wb_en   = 1'b0;
        bubble     = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FILL;
            S_FILL, S_RUN: begin
                // busy outranks a jump in EX; the jump waits for the resume
                if (bus.ex_busy) begin
                    state_d   = S_STALL;
                    ret_run_d = (state_q == S_RUN);
                end else if (!step_ok) begin
                    step_hold = 1'b1;
                end else if (state_q == S_RUN && ex_v_q && ex_instr_q[7]) begin
                    pc_load  = 1'b1;
                    id_ex_en = 1'b1;
                    ex_wb_en = 1'b1;
                    state_d  = S_FLUSH;
                end else begin
                    adv = 1'b1;
                    if (state_q == S_FILL && id_v_q) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_STALL: begin
                if (!bus.ex_busy) begin
                    state_d = ret_run_q ? S_RUN : S_FILL;
                end
            end
            S_FLUSH: begin
                if_id_en = 1'b1;
                id_ex_en = 1'b1;
                bubble   = 1'b1;
                state_d  = S_FILL;
            end
            default: state_d = S_RESET;
        endcase

        if (adv) begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            ex_wb_en = 1'b1;
        end

        // the target captured during FLUSH is refetched in FILL, so it stays invalid
        if (if_id_en) begin
            id_instr_d = bus.if_instr;
            id_v_d     = adv;
        end

        if (id_ex_en) begin
            if (bubble) begin
                ex_instr_d = 8'h00;
                ex_v_d     = 1'b0;
                fwd_a_d    = 1'b0;
                fwd_b_d    = 1'b0;
            end else begin
                ex_instr_d = id_instr_q;
                ex_v_d     = id_v_q;
                fwd_a_d    = id_v_q & (id_instr_q[7:6] == 2'b01) & ex_dst_ok
                           & (ex_instr_q[5:3] == id_instr_q[5:3]);
                fwd_b_d    = id_v_q & (id_instr_q[7:6] == 2'b00) & ex_dst_ok
                           & (ex_instr_q[5:3] == id_instr_q[2:0]);
            end
        end

        if (ex_wb_en) begin
            wb_v_d   = ex_v_q;
            wb_jmp_d = ex_instr_q[7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            ret_run_q  <= 1'b0;
            id_instr_q <= 8'h00;
            ex_instr_q <= 8'h00;
            id_v_q     <= 1'b0;
            ex_v_q     <= 1'b0;
            wb_v_q     <= 1'b0;
            wb_jmp_q   <= 1'b0;
            fwd_a_q    <= 1'b0;
            fwd_b_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_run_q  <= ret_run_d;
            id_instr_q <= id_instr_d;
            ex_instr_q <= ex_instr_d;
            id_v_q     <= id_v_d;
            ex_v_q     <= ex_v_d;
            wb_v_q     <= wb_v_d;
            wb_jmp_q   <= wb_jmp_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.pc_load      = pc_load;
    assign bus.pc_target    = ex_instr_q[6:0];
    assign bus.if_id_en     = if_id_en;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.ex_wb_en     = ex_wb_en;
    assign bus.id_ex_bubble = bubble;
    assign bus.fwd_a_sel    = fwd_a_q;
    assign bus.fwd_b_sel    = fwd_b_q;
    assign bus.wb_en        = wb_v_q & ~wb_jmp_q & (state_q != S_STALL) & ~step_hold;
    assign bus.state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// =============================================================================
// tb_pipe_ctrl : vector table + scoreboard bench for pipe_ctrl.
// Revision     : 1.0
// =============================================================================
module tb_pipe_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // enable field order: pc_en pc_load if_id id_ex ex_wb bubble fwd_a fwd_b wb_en
    localparam logic [8:0] c_e0    = 9'b000000000;
    localparam logic [8:0] c_adv   = 9'b101110000;
    localparam logic [8:0] c_advw  = 9'b101110001;
    localparam logic [8:0] c_advfb = 9'b101110011;
    localparam logic [8:0] c_advfa = 9'b101110101;
    localparam logic [8:0] c_jmp   = 9'b010110001;
    localparam logic [8:0] c_fls   = 9'b001101000;
    localparam logic [8:0] c_wbo   = 9'b000000001;

    localparam logic [2:0] c_rst = 3'd0, c_fill = 3'd1, c_run = 3'd2,
                           c_stall = 3'd3, c_flush = 3'd4;

    localparam logic [7:0] c_i = 8'b00_001_010;  // r1 <- f(r2)
    localparam logic [7:0] c_a = 8'b00_011_000;  // r3 <- f(r0)
    localparam logic [7:0] c_b = 8'b00_101_011;  // r5 <- f(rB=r3)
    localparam logic [7:0] c_c = 8'b01_011_111;  // r3 <- f(rA=r3)
    localparam logic [7:0] c_n = 8'b00_000_000;  // nop-like
    localparam logic [7:0] c_j = 8'b1_0101010;   // jump 0x2A

    typedef struct packed {
        logic        rstn;
        logic        busy;
        logic [7:0]  instr;
        logic [18:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [18:0] pack_out();
        return {bus.state, bus.pc_en, bus.pc_load, bus.if_id_en, bus.id_ex_en,
                bus.ex_wb_en, bus.id_ex_bubble, bus.fwd_a_sel, bus.fwd_b_sel,
                bus.wb_en, bus.pc_target};
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got state=%0d en=%b tgt=%h, want state=%0d en=%b tgt=%h",
                     name, act[18:16], act[15:7], act[6:0], exp[18:16], exp[15:7], exp[6:0]);
        end
    endtask

    task automatic add(input logic rn, input logic bz, input logic [7:0] ins,
                       input logic [2:0] st, input logic [8:0] en, input logic [6:0] tgt);
        vec_t v;
        v.rstn  = rn;
        v.busy  = bz;
        v.instr = ins;
        v.exp   = {st, en, tgt};
        vecs.push_back(v);
    endtask

    task automatic step_check(input string name, input logic bz, input logic [2:0] st,
                              input logic [8:0] en, input logic [6:0] tgt);
        @(posedge clk);
        #1;
        bus.ex_busy = bz;
        @(negedge clk);
        check(name, pack_out(), {st, en, tgt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_instr = c_i;
        bus.ex_busy  = 1'b0;
`ifdef PIPE_CTRL_STEP_EN
        bus.step     = 1'b1;
`endif
        // reset release, fill, run
        add(0, 0, c_i, c_rst,   c_e0,    7'h00);
        add(1, 0, c_i, c_rst,   c_e0,    7'h00);
        add(1, 0, c_i, c_fill,  c_adv,   7'h00);
        add(1, 0, c_i, c_fill,  c_adv,   7'h00);
        add(1, 0, c_i, c_run,   c_adv,   7'h0A);
        add(1, 0, c_i, c_run,   c_advw,  7'h0A);
        // rB forwarding: A then B
        add(1, 0, c_a, c_run,   c_advw,  7'h0A);
        add(1, 0, c_b, c_run,   c_advw,  7'h0A);
        add(1, 0, c_i, c_run,   c_advw,  7'h18);
        add(1, 0, c_a, c_run,   c_advfb, 7'h2B);
        // rA forwarding: A then C, then A, nop, C
        add(1, 0, c_c, c_run,   c_advw,  7'h0A);
        add(1, 0, c_a, c_run,   c_advw,  7'h18);
        add(1, 0, c_n, c_run,   c_advfa, 7'h5F);
        add(1, 0, c_c, c_run,   c_advw,  7'h18);
        add(1, 0, c_i, c_run,   c_advw,  7'h00);
        add(1, 0, c_j, c_run,   c_advw,  7'h5F);
        // jump through EX, flush, refill
        add(1, 0, c_i, c_run,   c_advw,  7'h0A);
        add(1, 0, c_i, c_run,   c_jmp,   7'h2A);
        add(1, 0, c_i, c_flush, c_fls,   7'h0A);
        add(1, 0, c_i, c_fill,  c_adv,   7'h00);
        add(1, 0, c_i, c_fill,  c_adv,   7'h0A);
        add(1, 0, c_i, c_run,   c_adv,   7'h0A);
        // busy for 3 cycles while the jump sits in ID
        add(1, 0, c_j, c_run,   c_advw,  7'h0A);
        add(1, 1, c_i, c_run,   c_wbo,   7'h0A);
        add(1, 1, c_i, c_stall, c_e0,    7'h0A);
        add(1, 1, c_i, c_stall, c_e0,    7'h0A);
        add(1, 0, c_i, c_stall, c_e0,    7'h0A);
        add(1, 0, c_i, c_run,   c_advw,  7'h0A);
        add(1, 0, c_i, c_run,   c_jmp,   7'h2A);

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            rst_n        = vecs[k].rstn;
            bus.ex_busy  = vecs[k].busy;
            bus.if_instr = vecs[k].instr;
            exp_q.push_back(vecs[k].exp);
            @(negedge clk);
            check($sformatf("vec%0d", k), pack_out(), exp_q.pop_front());
        end

        // asynchronous reset in the middle of FLUSH
        step_check("flush_before_rst", 1'b0, c_flush, c_fls, 7'h0A);
        rst_n = 1'b0;
        #1;
        check("rst_in_flush", pack_out(), {c_rst, c_e0, 7'h00});
        step_check("rst_held", 1'b0, c_rst, c_e0, 7'h00);

        // busy during FILL returns to FILL, then reaches RUN
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release", pack_out(), {c_rst, c_e0, 7'h00});
        step_check("fill_busy",   1'b1, c_fill,  c_e0,  7'h00);
        step_check("fill_stall",  1'b0, c_stall, c_e0,  7'h00);
        step_check("fill_resume", 1'b0, c_fill,  c_adv, 7'h00);
        step_check("fill_second", 1'b0, c_fill,  c_adv, 7'h00);
        step_check("fill_to_run", 1'b0, c_run,   c_adv, 7'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
